// File: rtl/mpmc10_rd_strip_collect.sv
// rtl/mpmc10_rd_strip_collect.sv - collects a burst of memory read strips into a line buffer
module mpmc10_rd_strip_collect #(
    parameter int WID         = 128,
    parameter int LINE_STRIPS = 4,
    parameter int TMO         = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [5:0]                 num_strips,
    input  logic [31:0]                addr_base,
    input  logic                       rd_data_valid,
    input  logic [WID-1:0]             rd_data,
    input  logic                       ack,
    output logic                       busy,
    output logic                       strip_valid,
    output logic [WID-1:0]             strip_data,
    output logic [31:0]                strip_addr,
    output logic [5:0]                 strip_cnt,
    output logic [WID*LINE_STRIPS-1:0] line,
    output logic                       done,
    output logic                       err,
    output logic                       stray
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    localparam int TW = $clog2(TMO + 1);

    state_t         state;
    logic [5:0]     nstr_q;
    logic [5:0]     cnt;
    logic [31:0]    base_q;
    logic [TW-1:0]  tmo_cnt;

    assign busy = (state == COLLECT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            nstr_q      <= '0;
            cnt         <= '0;
            base_q      <= '0;
            tmo_cnt     <= '0;
            strip_valid <= 1'b0;
            strip_data  <= '0;
            strip_addr  <= '0;
            strip_cnt   <= '0;
            line        <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            stray       <= 1'b0;
        end else begin
            strip_valid <= 1'b0;
            stray       <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_data_valid)
                        stray <= 1'b1;
                    if (start) begin
                        nstr_q  <= num_strips;
                        base_q  <= {addr_base[31:4], 4'h0};
                        cnt     <= '0;
                        tmo_cnt <= '0;
                        line    <= '0;
                        state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    // A beat always wins over a timeout landing on the same cycle.
                    if (rd_data_valid) begin
                        strip_valid <= 1'b1;
                        strip_data  <= rd_data;
                        strip_cnt   <= cnt;
                        strip_addr  <= base_q + {22'd0, cnt, 4'd0};
                        tmo_cnt     <= '0;
                        for (int i = 0; i < LINE_STRIPS; i++) begin
                            if (int'(cnt) == i)
                                line[i*WID +: WID] <= rd_data;
                        end
                        if (cnt == nstr_q) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b0;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end else if (tmo_cnt == TW'(TMO - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                DONE: begin
                    if (rd_data_valid)
                        stray <= 1'b1;
                    if (ack) begin
                        state <= IDLE;
                        done  <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mpmc10_rd_strip_collect.sv
// tb/tb_mpmc10_rd_strip_collect.sv - table-driven and directed bench for mpmc10_rd_strip_collect
module tb_mpmc10_rd_strip_collect;
    localparam int WID = 32;
    localparam int LS  = 4;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [5:0]      num_strips = '0;
    logic [31:0]     addr_base = '0;
    logic            rd_data_valid = 1'b0;
    logic [WID-1:0]  rd_data = '0;
    logic            ack = 1'b0;
    logic            busy, strip_valid, done, err, stray;
    logic [WID-1:0]  strip_data;
    logic [31:0]     strip_addr;
    logic [5:0]      strip_cnt;
    logic [WID*LS-1:0] line;

    int checks = 0;
    int errors = 0;

    mpmc10_rd_strip_collect #(.WID(WID), .LINE_STRIPS(LS), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .num_strips(num_strips),
        .addr_base(addr_base), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .ack(ack), .busy(busy), .strip_valid(strip_valid), .strip_data(strip_data),
        .strip_addr(strip_addr), .strip_cnt(strip_cnt), .line(line), .done(done),
        .err(err), .stray(stray)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic s; logic [5:0] n; logic [31:0] a; logic v; logic [31:0] d; logic k;
        logic e_busy; logic e_sv; logic [31:0] e_sd; logic [31:0] e_sa; logic [5:0] e_sc;
        logic e_done; logic e_err; logic e_stray; logic [127:0] e_line;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(logic s, logic [5:0] n, logic [31:0] a, logic v, logic [31:0] d,
                                logic k, logic eb, logic esv, logic [31:0] esd, logic [31:0] esa,
                                logic [5:0] esc, logic edn, logic eer, logic est, logic [127:0] eln);
        vec_t r;
        r.s = s; r.n = n; r.a = a; r.v = v; r.d = d; r.k = k;
        r.e_busy = eb; r.e_sv = esv; r.e_sd = esd; r.e_sa = esa; r.e_sc = esc;
        r.e_done = edn; r.e_err = eer; r.e_stray = est; r.e_line = eln;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic [5:0] n, input logic [31:0] a,
                        input logic v, input logic [31:0] d, input logic k);
        start = s; num_strips = n; addr_base = a; rd_data_valid = v; rd_data = d; ack = k;
        @(posedge clk);
        #1;
        start = 1'b0; rd_data_valid = 1'b0; ack = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic beat(input logic [31:0] d);
        step(1'b0, 6'd0, 32'd0, 1'b1, d, 1'b0);
    endtask

    localparam logic [31:0] D0 = 32'h1111_1111, D1 = 32'h2222_2222;
    localparam logic [31:0] D2 = 32'h3333_3333, D3 = 32'h4444_4444, B0 = 32'h5555_5555;

    initial begin
        logic [127:0] l4, lb;
        int n;
        l4 = {D3, D2, D1, D0};
        lb = {96'd0, B0};
        tbl[0]  = mk(1, 3, 32'h1234, 0, 0,  0, 1, 0, 0,  0,         0, 0, 0, 0, 128'd0);
        tbl[1]  = mk(0, 0, 0,        1, D0, 0, 1, 1, D0, 32'h1230,  0, 0, 0, 0, {96'd0, D0});
        tbl[2]  = mk(0, 0, 0,        1, D1, 0, 1, 1, D1, 32'h1240,  1, 0, 0, 0, {64'd0, D1, D0});
        tbl[3]  = mk(0, 0, 0,        1, D2, 0, 1, 1, D2, 32'h1250,  2, 0, 0, 0, {32'd0, D2, D1, D0});
        tbl[4]  = mk(0, 0, 0,        1, D3, 0, 0, 1, D3, 32'h1260,  3, 1, 0, 0, l4);
        tbl[5]  = mk(0, 0, 0,        0, 0,  0, 0, 0, D3, 32'h1260,  3, 1, 0, 0, l4);
        tbl[6]  = mk(1, 0, 0,        0, 0,  0, 0, 0, D3, 32'h1260,  3, 1, 0, 0, l4);
        tbl[7]  = mk(0, 0, 0,        1, 32'h9999, 0, 0, 0, D3, 32'h1260, 3, 1, 0, 1, l4);
        tbl[8]  = mk(0, 0, 0,        0, 0,  1, 0, 0, D3, 32'h1260,  3, 0, 0, 0, l4);
        tbl[9]  = mk(0, 0, 0,        1, 32'h7777, 0, 0, 0, D3, 32'h1260, 3, 0, 0, 1, l4);
        tbl[10] = mk(1, 0, 32'h100,  0, 0,  0, 1, 0, D3, 32'h1260,  3, 0, 0, 0, 128'd0);
        tbl[11] = mk(0, 0, 0,        1, B0, 0, 0, 1, B0, 32'h100,   0, 1, 0, 0, lb);
        tbl[12] = mk(1, 3, 0,        0, 0,  1, 0, 0, B0, 32'h100,   0, 0, 0, 0, lb);
        tbl[13] = mk(0, 0, 0,        0, 0,  0, 0, 0, B0, 32'h100,   0, 0, 0, 0, lb);
        tbl[14] = mk(0, 0, 0,        0, 0,  1, 0, 0, B0, 32'h100,   0, 0, 0, 0, lb);

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_strip_valid", strip_valid, 0);
        check("reset_strip_data", strip_data, 0);
        check("reset_strip_addr", strip_addr, 0);
        check("reset_strip_cnt", strip_cnt, 0);
        check("reset_line", line, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_stray", stray, 0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].s, tbl[i].n, tbl[i].a, tbl[i].v, tbl[i].d, tbl[i].k);
            check($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            check($sformatf("v%0d_strip_valid", i), strip_valid, tbl[i].e_sv);
            check($sformatf("v%0d_strip_data", i), strip_data, tbl[i].e_sd);
            check($sformatf("v%0d_strip_addr", i), strip_addr, tbl[i].e_sa);
            check($sformatf("v%0d_strip_cnt", i), strip_cnt, tbl[i].e_sc);
            check($sformatf("v%0d_done", i), done, tbl[i].e_done);
            check($sformatf("v%0d_err", i), err, tbl[i].e_err);
            check($sformatf("v%0d_stray", i), stray, tbl[i].e_stray);
            check($sformatf("v%0d_line", i), line, tbl[i].e_line);
        end

        // six beats with idle gaps; only the first four land in the line
        step(1'b1, 6'd5, 32'h2000, 1'b0, 32'd0, 1'b0);
        for (int b = 0; b < 6; b++) begin
            for (int g = 0; g <= b % 2; g++) begin
                idle();
                check($sformatf("gap%0d_strip_valid", b), strip_valid, 0);
            end
            beat(32'hC000_0000 + b);
            check($sformatf("gap%0d_beat_valid", b), strip_valid, 1);
            check($sformatf("gap%0d_beat_cnt", b), strip_cnt, b);
            check($sformatf("gap%0d_beat_addr", b), strip_addr, 32'h2000 + 16 * b);
        end
        check("gap_done", done, 1);
        check("gap_err", err, 0);
        check("gap_line", line, {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000});
        step(1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b1);

        // timeout: one beat then silence
        step(1'b1, 6'd2, 32'h0, 1'b0, 32'd0, 1'b0);
        beat(32'hAAAA_0000);
        n = 0;
        while (!done && n < 20) begin
            idle();
            n++;
        end
        check("tmo_cycles", n, 8);
        check("tmo_done", done, 1);
        check("tmo_err", err, 1);
        check("tmo_busy", busy, 0);
        step(1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        check("tmo_ack_err", err, 0);

        // beat landing on the timeout cycle is accepted
        step(1'b1, 6'd2, 32'h0, 1'b0, 32'd0, 1'b0);
        beat(32'hBBBB_0000);
        repeat (7) idle();
        check("tmo_edge_pre_done", done, 0);
        beat(32'hBBBB_0001);
        check("tmo_edge_accept_valid", strip_valid, 1);
        check("tmo_edge_accept_cnt", strip_cnt, 1);
        check("tmo_edge_busy", busy, 1);
        check("tmo_edge_done", done, 0);
        repeat (8) idle();
        check("tmo_edge_late_err", err, 1);
        step(1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b1);

        // address wrap
        step(1'b1, 6'd1, 32'hFFFF_FFF0, 1'b0, 32'd0, 1'b0);
        beat(32'h0);
        check("wrap_addr0", strip_addr, 32'hFFFF_FFF0);
        beat(32'h1);
        check("wrap_addr1", strip_addr, 32'h0000_0000);
        check("wrap_done", done, 1);
        step(1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b1);

        // 64-beat burst; counter reaches 63 without wrapping
        step(1'b1, 6'd63, 32'h0, 1'b0, 32'd0, 1'b0);
        for (int b = 0; b < 63; b++) beat(b);
        check("max_pre_done", done, 0);
        beat(32'd63);
        check("max_cnt", strip_cnt, 63);
        check("max_addr", strip_addr, 32'h3F0);
        check("max_done", done, 1);
        step(1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b1);

        // asynchronous reset mid-burst
        step(1'b1, 6'd3, 32'h4000, 1'b0, 32'd0, 1'b0);
        beat(32'hD0);
        beat(32'hD1);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_strip_valid", strip_valid, 0);
        check("rst_strip_data", strip_data, 0);
        check("rst_strip_addr", strip_addr, 0);
        check("rst_strip_cnt", strip_cnt, 0);
        check("rst_line", line, 0);
        check("rst_done", done, 0);
        #2 rst = 1'b0;
        beat(32'hD2);
        check("rst_after_stray", stray, 1);
        check("rst_after_busy", busy, 0);
        beat(32'hD3);
        idle();
        check("rst_after_done", done, 0);
        check("rst_after_line", line, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mpmc10_rd_strip_collect.md
MPMC10_RD_STRIP_COLLECT -- requirements
Module: mpmc10_rd_strip_collect

Interface
REQ-001 SHALL have parameter WID, default 128, meaning strip (beat) data width in bits.
REQ-002 SHALL have parameter LINE_STRIPS, default 4, meaning number of strips captured into the line buffer.
REQ-003 SHALL have parameter TMO, default 1023, meaning idle-beat cycles before timeout.
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port start  input  1  single-cycle request to begin collecting a burst sequence.
REQ-007 SHALL have port num_strips  input  6  last strip index; the burst is num_strips+1 beats.
REQ-008 SHALL have port addr_base  input  32  byte address of the first strip.
REQ-009 SHALL have port rd_data_valid  input  1  memory read-data beat valid.
REQ-010 SHALL have port rd_data  input  WID  memory read-data beat.
REQ-011 SHALL have port ack  input  1  consumer acknowledge of done.
REQ-012 SHALL have port busy  output  1  high while collecting.
REQ-013 SHALL have port strip_valid  output  1  one-cycle pulse per accepted beat.
REQ-014 SHALL have port strip_data  output  WID  registered copy of the accepted beat.
REQ-015 SHALL have port strip_addr  output  32  byte address of the accepted beat.
REQ-016 SHALL have port strip_cnt  output  6  index of the accepted beat.
REQ-017 SHALL have port line  output  WID*LINE_STRIPS  assembled line; strip i at bits [i*WID +: WID].
REQ-018 SHALL have port done  output  1  sequence complete; held until ack.
REQ-019 SHALL have port err  output  1  timeout flag; valid while done=1.
REQ-020 SHALL have port stray  output  1  one-cycle pulse when a beat arrives outside COLLECT.

Function
REQ-021 SHALL implement states IDLE, COLLECT and DONE.
REQ-022 In IDLE, start SHALL latch num_strips and {addr_base[31:4],4'h0}, clear the beat counter, timeout counter and line, and enter COLLECT next cycle.
REQ-023 start outside IDLE SHALL be ignored.
REQ-024 busy SHALL equal (state==COLLECT).
REQ-025 In COLLECT, each rd_data_valid beat SHALL, one cycle later, drive strip_valid=1, strip_data=rd_data, strip_cnt=current count, and strip_addr=latched base + count*16, modulo 2^32.
REQ-026 A beat with count < LINE_STRIPS SHALL write line slice [count]; other beats SHALL leave line unchanged.
REQ-027 A beat with count == latched num_strips SHALL move the block to DONE with err=0; otherwise the count SHALL increment by 1.
REQ-028 The counter SHALL NOT wrap: for num_strips=63 the last beat has count 63.
REQ-029 The timeout counter SHALL clear on every COLLECT beat and increment on every COLLECT cycle without a beat.
REQ-030 When the timeout counter reaches TMO without a beat, the block SHALL enter DONE with err=1.
REQ-031 A beat arriving in the same cycle that TMO is reached SHALL be accepted, and the timeout SHALL NOT occur.
REQ-032 In DONE, done SHALL be 1 and line SHALL hold its value.
REQ-033 In DONE, ack SHALL return the block to IDLE next cycle and clear done and err.
REQ-034 start asserted in the same cycle as ack SHALL be ignored.
REQ-035 ack in IDLE or COLLECT SHALL be ignored.
REQ-036 rd_data_valid in IDLE or DONE SHALL be dropped, pulse stray for one cycle, and change no other output.
REQ-037 strip_valid SHALL be 0 on every cycle not following an accepted beat; strip_data, strip_addr and strip_cnt SHALL hold between beats.

Reset
REQ-038 On rst, the block SHALL asynchronously enter IDLE.
REQ-039 On rst, busy, strip_valid, strip_data, strip_addr, strip_cnt, line, done, err and stray SHALL all become 0.
REQ-040 On rst, all internal counters and latched values SHALL be cleared.
REQ-041 rst asserted mid-COLLECT SHALL abandon the sequence without asserting done.

Verification
REQ-042 Bench SHALL cover: start, num_strips=3, addr_base=32'h0000_1234, 4 back-to-back beats D0..D3 -> strip_addr 1230/1240/1250/1260, strip_cnt 0..3, line={D3,D2,D1,D0}, done=1, err=0.
REQ-043 Bench SHALL cover: num_strips=0, one beat -> single strip_valid, done next cycle, ack -> IDLE, done=0.
REQ-044 Bench SHALL cover: num_strips=5, 6 beats with gaps -> line holds beats 0..3 only, strip_cnt reaches 5, done=1.
REQ-045 Bench SHALL cover: TMO=8, num_strips=2, one beat then silence -> done=1, err=1 eight cycles after the last beat.
REQ-046 Bench SHALL cover: beat in IDLE -> stray pulse, line unchanged.
REQ-047 Bench SHALL cover: start during DONE -> ignored.
REQ-048 Bench SHALL cover: addr_base=32'hFFFF_FFF0, num_strips=1 -> strip_addr FFFF_FFF0 then 0000_0000.
REQ-049 Bench SHALL cover: rst pulse after 2 of 4 beats -> all outputs 0, state IDLE, no done.
